// File: rtl/stream_distributor.sv
// -----------------------------------------------------------------------------
// stream_distributor
//
// Takes a transfer command (destination buffer, filter SRAM index, beat count),
// accepts AXI-Stream beats and splits each DATA_W beat into DATA_W/VALUE_W
// values. Values are emitted low lane first. Each value carries the latched
// destination tag and a running write address. The downstream side can apply
// backpressure.
//
// Optional build macro: DIST_LEN_CHECK_EN
//   defined   : len_err is a sticky length-mismatch flag, cleared by the next
//               command handshake
//   undefined : len_err is tied to 0 and no checking logic is built
//
// Ports
//   clk, reset                 single clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_buf, cmd_sram, cmd_len destination buffer, filter SRAM, beat count
//                              (cmd_len 0 = unbounded, ends on TLAST only)
//   S_AXIS_TDATA/TVALID/TLAST/TREADY  AXI-Stream slave
//   out_valid/out_ready        value handshake towards the buffers
//   out_value, out_buf, out_sram, out_addr, out_last  value and its tags
//   done                       one-cycle pulse after the final value handshake
//   len_err                    length mismatch flag (see macro above)
// -----------------------------------------------------------------------------
module stream_distributor #(
  parameter int DATA_W   = 32,
  parameter int VALUE_W  = 16,
  parameter int NUM_BUF  = 4,
  parameter int NUM_SRAM = 4,
  parameter int LEN_W    = 16,
  parameter int ADDR_W   = 12,
  localparam int BUF_W   = (NUM_BUF  > 1) ? $clog2(NUM_BUF)  : 1,
  localparam int SRAM_W  = (NUM_SRAM > 1) ? $clog2(NUM_SRAM) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [BUF_W-1:0]  cmd_buf,
  input  logic [SRAM_W-1:0] cmd_sram,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] S_AXIS_TDATA,
  input  logic              S_AXIS_TVALID,
  input  logic              S_AXIS_TLAST,
  output logic              S_AXIS_TREADY,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VALUE_W-1:0] out_value,
  output logic [BUF_W-1:0]  out_buf,
  output logic [SRAM_W-1:0] out_sram,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              done,
  output logic              len_err
);

  localparam int LANES  = DATA_W / VALUE_W;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [LANES-1:0][VALUE_W-1:0] hold;
  logic                          hold_full;
  logic [LANE_W-1:0]             lane;
  logic [LEN_W-1:0]              beat_cnt;
  logic [LEN_W-1:0]              len_q;
  logic [BUF_W-1:0]              buf_q;
  logic [SRAM_W-1:0]             sram_q;
  logic [ADDR_W-1:0]             addr_q;
  logic                          final_captured;

  logic              cmd_fire;
  logic              in_fire;
  logic              out_fire;
  logic              at_last_lane;
  logic [LEN_W:0]    beat_next;
  logic              len_hit;
  logic              beat_final;

  // One extra bit so a count that reaches 2^LEN_W-1 never aliases to zero.
  assign beat_next    = {1'b0, beat_cnt} + (LEN_W + 1)'(1);
  assign len_hit      = (len_q != '0) && (beat_next == {1'b0, len_q});
  assign beat_final   = S_AXIS_TLAST | len_hit;
  assign at_last_lane = (lane == LAST_LANE);

  assign cmd_fire = cmd_valid & cmd_ready;
  assign in_fire  = S_AXIS_TVALID & S_AXIS_TREADY;
  assign out_fire = out_valid & out_ready;

  assign out_valid = hold_full & ~reset;
  assign out_value = hold[lane];
  // Once the final beat is in, nothing newer can enter the hold register, so
  // final_captured also tells us the held beat is the final one.
  assign out_last  = out_valid & at_last_lane & final_captured;
  assign out_buf   = buf_q;
  assign out_sram  = sram_q;
  assign out_addr  = addr_q;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: every sequential block uses non-blocking (<=) assignments so all
  // registers update together from the values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    cmd_ready     = 1'b0;
    S_AXIS_TREADY = 1'b0;
    done          = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = ~reset;
        if (cmd_valid) state_nxt = RECV;
      end
      RECV: begin
        // A new beat may load in the same cycle the last lane drains, which
        // keeps one value per cycle flowing without bubbles.
        S_AXIS_TREADY = ~reset & ~final_captured &
                        (~hold_full | (at_last_lane & out_ready));
        if (out_fire && out_last) state_nxt = DONE;
      end
      DONE: begin
        done      = ~reset;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: command latch, hold register, lane and address counters
  // ---------------------------------------------------------------------------
  // NOTE: the hold register is a plain DATA_W flop, not a memory array, so
  // clearing it on reset is cheap and keeps out_value deterministic.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold           <= '0;
      hold_full      <= 1'b0;
      lane           <= '0;
      beat_cnt       <= '0;
      len_q          <= '0;
      buf_q          <= '0;
      sram_q         <= '0;
      addr_q         <= '0;
      final_captured <= 1'b0;
    end else begin
      if (cmd_fire) begin
        buf_q          <= cmd_buf;
        sram_q         <= cmd_sram;
        len_q          <= cmd_len;
        beat_cnt       <= '0;
        addr_q         <= '0;
        final_captured <= 1'b0;
        hold_full      <= 1'b0;
        lane           <= '0;
      end

      if (out_fire) begin
        addr_q <= addr_q + 1'b1;
        if (at_last_lane) begin
          lane      <= '0;
          hold_full <= 1'b0;
        end else begin
          lane <= lane + 1'b1;
        end
      end

      // A captured beat takes priority over the drain of the previous one.
      if (in_fire) begin
        hold      <= S_AXIS_TDATA;
        hold_full <= 1'b1;
        lane      <= '0;
        beat_cnt  <= beat_next[LEN_W-1:0];
        if (beat_final) final_captured <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional length check
  // ---------------------------------------------------------------------------
`ifdef DIST_LEN_CHECK_EN
  logic len_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      len_err_q <= 1'b0;
    end else if (cmd_fire) begin
      len_err_q <= 1'b0;
    end else if (in_fire && (len_q != '0)) begin
      // Early TLAST, or the expected beat count reached without TLAST.
      if ((S_AXIS_TLAST && (beat_next < {1'b0, len_q})) ||
          (len_hit && !S_AXIS_TLAST))
        len_err_q <= 1'b1;
    end
  end

  assign len_err = len_err_q;
`else
  assign len_err = 1'b0;
`endif

endmodule

// File: doc/stream_distributor.md
Name: stream_distributor

Overview:
- Parametrised successor of the accelerator's AXI-Stream input distributor.
- Accepts a transfer command from the controller: destination buffer (image/filter/bias/...), filter SRAM index and beat count.
- Receives AXI-Stream beats and unpacks each DATA_W beat into DATA_W/VALUE_W values, emitted low lane first.
- Each emitted value carries a destination tag and a running write address, with backpressure towards the buffers.

Parameters:
DATA_W, 32, AXI-Stream data width; must be an integer multiple of VALUE_W
VALUE_W, 16, width of one stored value
NUM_BUF, 4, number of destination buffers; BUF_W = clog2(NUM_BUF)
NUM_SRAM, 4, number of SRAMs inside the filter buffer; SRAM_W = clog2(NUM_SRAM)
LEN_W, 16, width of the beat-count field
ADDR_W, 12, width of the per-transfer value address

Ports:
clk  in  1  single clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  controller command valid
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_buf  in  BUF_W  destination buffer select
cmd_sram  in  SRAM_W  filter SRAM select
cmd_len  in  LEN_W  beats expected; 0 = unbounded, terminate on TLAST only
S_AXIS_TDATA  in  DATA_W  stream data
S_AXIS_TVALID  in  1  stream valid
S_AXIS_TLAST  in  1  last beat of packet
S_AXIS_TREADY  out  1  stream ready
out_valid  out  1  unpacked value valid
out_ready  in  1  downstream buffer ready
out_value  out  VALUE_W  unpacked value
out_buf  out  BUF_W  latched cmd_buf
out_sram  out  SRAM_W  latched cmd_sram
out_addr  out  ADDR_W  value index within the transfer
out_last  out  1  final value of the transfer
done  out  1  one-cycle pulse after the final value handshake
len_err  out  1  length mismatch flag (see Optional Feature)

Behaviour:
- Interface fixed: one clock; reset is synchronous and active-high.
- Reset values:
  - State IDLE; cmd_ready=0 during reset, 1 from the first IDLE cycle after reset.
  - S_AXIS_TREADY=0, out_valid=0, out_last=0, done=0, len_err=0.
  - out_addr=0, out_buf=0, out_sram=0.
  - Hold register and lane counter cleared.
- Reset asserted mid-transfer aborts immediately: the held beat is discarded and no done pulse is produced.
- FSM states: IDLE, RECV, DONE.
  - IDLE: cmd_ready=1. On cmd handshake, latch buf/sram/len, clear beat counter and out_addr, go to RECV.
  - RECV: accept beats and unpack them. After the final value handshake, go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE. cmd_ready=0 in RECV and DONE.
- Unpacking: one hold register of DATA_W bits plus a lane counter 0..LANES-1, where LANES = DATA_W/VALUE_W.
  - out_value = lane[k] = hold[k*VALUE_W +: VALUE_W].
  - out_valid=1 while the hold register is full.
  - The lane advances on out_valid & out_ready.
- S_AXIS_TREADY = (state==RECV) & (hold empty | (last lane & out_ready) ) & ~final_captured. This is combinational from out_ready and lets a new beat load in the same cycle the last lane drains, giving one value per cycle sustained.
- Beat capture on TVALID & TREADY:
  - Beat counter increments.
  - The beat is final if TLAST=1, or if cmd_len≠0 and beat counter+1 == cmd_len.
  - Once the final beat is captured, TREADY stays 0 until the next command.
- out_addr increments on every out handshake and wraps modulo 2^ADDR_W without a flag.
- out_last=1 only on the last lane of the final beat. Its handshake moves the FSM to DONE.
- out_value is stable, and out_valid does not drop, while out_valid=1 and out_ready=0.
- TLAST and a cmd_len match on the same beat give a single termination, not an error.
- TVALID outside RECV is ignored; TREADY=0 there.

Optional Feature:
- Macro: DIST_LEN_CHECK_EN.
- Defined: len_err is a sticky register, set in RECV when either:
  - TLAST arrives on beat n < cmd_len, or
  - beat cmd_len is captured with TLAST=0 (cmd_len≠0).
- len_err clears on the next command handshake. Termination behaviour is unchanged by the flag.
- Undefined: len_err is tied to 0 and no checking logic is built.

Test Plan:
- Defaults; cmd buf=1 sram=2 len=2; beats 0x00020001, 0x00040003 (TLAST on 2nd); out_ready=1 → values 1,2,3,4 with addr 0..3, out_buf=1, out_sram=2, out_last on value 4, done one cycle later, no bubbles after the first value.
- Same stream with out_ready toggling 1,0,1,0 → value sequence unchanged, out_value held during stalls, TREADY only high when draining.
- cmd len=0; 3 beats, TLAST on 3rd → 6 values, out_last on addr 5, no len_err.
- cmd len=4; TLAST on beat 2 → terminates after 4 values; len_err=1 with DIST_LEN_CHECK_EN, 0 without; the next cmd clears it.
- reset=1 for one cycle after beat 1 is captured → all outputs return to reset values next cycle, no done; a new cmd len=1 then completes normally with addr starting at 0.
- ADDR_W=2, cmd len=3 → out_addr sequence 0,1,2,3,0,1.
